// File: rtl/rvr32_reg_dbg_if.sv
// Debug-side regfile access bundle: command/response streams, halt handshake
// and the stolen regfile ports A (write) and B (read).
interface rvr32_reg_dbg_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic        cmd_dump;
    logic [4:0]  cmd_regno;
    logic [31:0] cmd_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        resp_last;
    logic        halt_req;
    logic        halt_ack;
    logic        rf_sel;
    logic [4:0]  rf_addr_a;
    logic [31:0] rf_wdata_a;
    logic        rf_we_a;
    logic [4:0]  rf_addr_b;
    logic [31:0] rf_rdata_b;

    modport slave (
        input  cmd_valid, cmd_write, cmd_dump, cmd_regno, cmd_wdata,
        input  resp_ready, halt_ack, rf_rdata_b,
        output cmd_ready, resp_valid, resp_rdata, resp_err, resp_last,
        output halt_req, rf_sel, rf_addr_a, rf_wdata_a, rf_we_a, rf_addr_b
    );

    modport master (
        output cmd_valid, cmd_write, cmd_dump, cmd_regno, cmd_wdata,
        output resp_ready, halt_ack, rf_rdata_b,
        input  cmd_ready, resp_valid, resp_rdata, resp_err, resp_last,
        input  halt_req, rf_sel, rf_addr_a, rf_wdata_a, rf_we_a, rf_addr_b
    );
endinterface

// File: rtl/rvr32_reg_dbg.sv
// Debug initiator for the rvr32 register file: halts the core, borrows regfile ports A/B for one access.
// Optional burst dump of x1..x31 is enabled by defining RVR32_REG_DBG_DUMP_EN.
module rvr32_reg_dbg #(
    parameter int unsigned HALT_TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    rvr32_reg_dbg_if.slave bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_HALT_WAIT = 3'd1;
    localparam logic [2:0] S_ACCESS    = 3'd2;
    localparam logic [2:0] S_RESP      = 3'd3;
`ifdef RVR32_REG_DBG_DUMP_EN
    localparam logic [2:0] S_DUMP_RD   = 3'd4;
    localparam logic [2:0] S_DUMP_RESP = 3'd5;
`endif
    localparam logic [7:0] TO_LAST = 8'(HALT_TIMEOUT - 1);

    logic [2:0]  r_state;
    logic        r_write;
    logic [4:0]  r_regno;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_halt;
    logic        r_sel;
    logic [7:0]  r_cnt;
`ifdef RVR32_REG_DBG_DUMP_EN
    logic        r_dump;
`endif
    logic        w_accept;
    logic [31:0] w_rd_b;

    assign w_accept = (r_state == S_IDLE) && bus.cmd_valid;
    assign w_rd_b   = (r_regno == 5'd0) ? 32'd0 : bus.rf_rdata_b;

    // Write data only reaches the regfile while rf_sel is high, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept)
            r_wdata <= bus.cmd_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_write <= 1'b0;
            r_regno <= 5'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
            r_halt  <= 1'b0;
            r_sel   <= 1'b0;
            r_cnt   <= 8'd0;
`ifdef RVR32_REG_DBG_DUMP_EN
            r_dump  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_write <= bus.cmd_write & ~bus.cmd_dump;
                        r_regno <= bus.cmd_regno;
                        r_cnt   <= 8'd0;
`ifdef RVR32_REG_DBG_DUMP_EN
                        r_dump  <= bus.cmd_dump;
                        r_halt  <= 1'b1;
                        r_state <= S_HALT_WAIT;
`else
                        if (bus.cmd_dump) begin
                            r_err   <= 1'b1;
                            r_rdata <= 32'd0;
                            r_state <= S_RESP;
                        end else begin
                            r_halt  <= 1'b1;
                            r_state <= S_HALT_WAIT;
                        end
`endif
                    end
                end
                S_HALT_WAIT: begin
                    // A late ack still wins over a timeout in the same cycle.
                    if (bus.halt_ack) begin
                        r_sel <= 1'b1;
`ifdef RVR32_REG_DBG_DUMP_EN
                        if (r_dump) begin
                            r_regno <= 5'd1;
                            r_state <= S_DUMP_RD;
                        end else begin
                            r_state <= S_ACCESS;
                        end
`else
                        r_state <= S_ACCESS;
`endif
                    end else if (r_cnt == TO_LAST) begin
                        r_halt  <= 1'b0;
                        r_err   <= 1'b1;
                        r_rdata <= 32'd0;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_ACCESS: begin
                    r_rdata <= r_write ? 32'd0 : w_rd_b;
                    r_sel   <= 1'b0;
                    r_halt  <= 1'b0;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_err   <= 1'b0;
                        r_rdata <= 32'd0;
                        r_state <= S_IDLE;
                    end
                end
`ifdef RVR32_REG_DBG_DUMP_EN
                S_DUMP_RD: begin
                    r_rdata <= bus.rf_rdata_b;
                    r_state <= S_DUMP_RESP;
                end
                S_DUMP_RESP: begin
                    // The core stays halted across response backpressure until x31 is consumed.
                    if (bus.resp_ready) begin
                        if (r_regno == 5'd31) begin
                            r_sel   <= 1'b0;
                            r_halt  <= 1'b0;
                            r_rdata <= 32'd0;
                            r_state <= S_IDLE;
                        end else begin
                            r_regno <= r_regno + 5'd1;
                            r_state <= S_DUMP_RD;
                        end
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = (r_state == S_IDLE);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
    assign bus.halt_req   = r_halt;
    assign bus.rf_sel     = r_sel;
`ifdef RVR32_REG_DBG_DUMP_EN
    assign bus.resp_valid = (r_state == S_RESP) || (r_state == S_DUMP_RESP);
    assign bus.resp_last  = (r_state == S_RESP) || ((r_state == S_DUMP_RESP) && (r_regno == 5'd31));
`else
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_last  = (r_state == S_RESP);
`endif
    assign bus.rf_we_a    = (r_state == S_ACCESS) && r_write && (r_regno != 5'd0);
    assign bus.rf_addr_a  = r_sel ? r_regno : 5'd0;
    assign bus.rf_wdata_a = r_sel ? r_wdata : 32'd0;
    assign bus.rf_addr_b  = r_sel ? r_regno : 5'd0;
endmodule

// File: tb/tb_rvr32_reg_dbg.sv
// Bench for rvr32_reg_dbg: regfile model, response scoreboard from command semantics, directed scenarios.
module tb_rvr32_reg_dbg;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    rvr32_reg_dbg_if bus ();

    rvr32_reg_dbg #(.HALT_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] mem [32];
    logic [31:0] mdl [32];
    beat_t       exp_q [$];
    beat_t       e;
    int checks = 0, errors = 0, cyc = 0;
    int we_cnt, sel_cnt, halt_cnt, beat_cnt, last_cnt, acc_cyc, rsp_cyc;
    logic [4:0]  we_addr;
    logic [31:0] we_data, last_rdata, p_rdata;
    logic        last_err, last_last, p_err, p_last, prev_hold, rv_prev;

    always @(posedge clk) begin
        cyc++;
        if (bus.rf_we_a) mem[bus.rf_addr_a] <= bus.rf_wdata_a;
    end
    assign bus.rf_rdata_b = mem[bus.rf_addr_b];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
        end
    endtask

    task automatic bound_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=no-event required=event-within-bound", nm);
    endtask

    task automatic clr();
        we_cnt = 0; sel_cnt = 0; halt_cnt = 0; beat_cnt = 0; last_cnt = 0;
        acc_cyc = 0; rsp_cyc = 0; we_addr = 0; we_data = 0;
    endtask

    // One compare process: scoreboard pops on every consumed beat plus per-cycle port rules.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
            rv_prev   = 1'b0;
        end else begin
            if (bus.rf_we_a) begin we_cnt++; we_addr = bus.rf_addr_a; we_data = bus.rf_wdata_a; end
            if (bus.rf_sel) begin
                sel_cnt++;
                chk("halt_held_with_sel", 32'(bus.halt_req), 32'd1);
            end else begin
                chk("rf_addr_quiet", {22'd0, bus.rf_addr_a, bus.rf_addr_b}, 32'd0);
                chk("rf_wdata_quiet", bus.rf_wdata_a, 32'd0);
                chk("rf_we_quiet", 32'(bus.rf_we_a), 32'd0);
            end
            if (bus.halt_req) halt_cnt++;
            if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
            if (bus.resp_valid && !rv_prev) rsp_cyc = cyc;
            rv_prev = bus.resp_valid;
            if (prev_hold) begin
                chk("hold_valid", 32'(bus.resp_valid), 32'd1);
                chk("hold_rdata", bus.resp_rdata, p_rdata);
                chk("hold_err_last", {30'd0, bus.resp_err, bus.resp_last}, {30'd0, p_err, p_last});
            end
            prev_hold = bus.resp_valid && !bus.resp_ready;
            p_rdata = bus.resp_rdata; p_err = bus.resp_err; p_last = bus.resp_last;
            if (bus.resp_valid && bus.resp_ready) begin
                beat_cnt++;
                if (bus.resp_last) last_cnt++;
                last_rdata = bus.resp_rdata; last_err = bus.resp_err; last_last = bus.resp_last;
                if (exp_q.size() == 0) begin
                    bound_fail("unexpected_beat");
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_rdata", bus.resp_rdata, e.rdata);
                    chk("beat_err", 32'(bus.resp_err), 32'(e.err));
                    chk("beat_last", 32'(bus.resp_last), 32'(e.last));
                end
            end
        end
    end

    // Expected beats straight from command semantics; the model regfile tracks architectural state.
    task automatic expect_cmd(input logic wr, input logic dp, input logic [4:0] r,
                              input logic [31:0] d, input bit to);
        beat_t b;
`ifdef RVR32_REG_DBG_DUMP_EN
        if (dp && !to) begin
            for (int i = 1; i < 32; i++) begin
                b = '{rdata: mdl[i], err: 1'b0, last: (i == 31)};
                exp_q.push_back(b);
            end
            return;
        end
`endif
        if (dp || to) b = '{rdata: 32'd0, err: 1'b1, last: 1'b1};
        else if (wr) begin
            if (r != 5'd0) mdl[r] = d;
            b = '{rdata: 32'd0, err: 1'b0, last: 1'b1};
        end else b = '{rdata: (r == 5'd0) ? 32'd0 : mdl[r], err: 1'b0, last: 1'b1};
        exp_q.push_back(b);
    endtask

    task automatic send(input logic wr, input logic dp, input logic [4:0] r, input logic [31:0] d);
        bit got = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_dump = dp;
        bus.cmd_regno = r; bus.cmd_wdata = d;
        for (int i = 0; i < 100 && !got; i++) begin @(negedge clk); got = bus.cmd_ready; end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_dump = 1'b0;
        if (!got) bound_fail("cmd_accept");
    endtask

    task automatic wait_done(input bit rnd);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.cmd_ready) begin bus.resp_ready = 1'b1; return; end
            if (rnd) begin @(posedge clk); #1; bus.resp_ready = 1'($urandom_range(0, 1)); end
        end
        bus.resp_ready = 1'b1;
        bound_fail("cmd_complete");
    endtask

    task automatic issue(input logic wr, input logic dp, input logic [4:0] r,
                         input logic [31:0] d, input bit to);
        expect_cmd(wr, dp, r, d, to);
        send(wr, dp, r, d);
        wait_done(1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, "_resp_flags"}, {29'd0, bus.resp_valid, bus.resp_err, bus.resp_last}, 32'd0);
        chk({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
        chk({tag, "_halt_sel_we"}, {29'd0, bus.halt_req, bus.rf_sel, bus.rf_we_a}, 32'd0);
    endtask

    task automatic mid_reset(input string tag);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        check_reset_outputs(tag);
        exp_q.delete();
        @(posedge clk); #1; rst = 1'b0;
    endtask

    initial begin
        bit got;
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_dump = 1'b0;
        bus.cmd_regno = 5'd0; bus.cmd_wdata = 32'd0;
        bus.resp_ready = 1'b1; bus.halt_ack = 1'b1;
        clr();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1; rst = 1'b0;

        clr();
        issue(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0);
        chk("wr5_we_count", 32'(we_cnt), 32'd1);
        chk("wr5_we_addr", 32'(we_addr), 32'd5);
        chk("wr5_we_data", we_data, 32'hDEADBEEF);
        chk("wr5_latency", 32'(rsp_cyc - acc_cyc), 32'd3);
        chk("wr5_regfile", mem[5], 32'hDEADBEEF);

        clr();
        issue(1'b0, 1'b0, 5'd5, 32'd0, 1'b0);
        chk("rd5_rdata", last_rdata, 32'hDEADBEEF);
        chk("rd5_err_last", {30'd0, last_err, last_last}, 32'd1);
        chk("rd5_sel_cycles", 32'(sel_cnt), 32'd1);

        clr();
        issue(1'b1, 1'b0, 5'd0, 32'h12345678, 1'b0);
        chk("wr0_we_count", 32'(we_cnt), 32'd0);
        chk("wr0_err", 32'(last_err), 32'd0);
        issue(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("rd0_rdata", last_rdata, 32'd0);

        clr();
        bus.halt_ack = 1'b0;
        issue(1'b0, 1'b0, 5'd7, 32'd0, 1'b1);
        chk("to_halt_cycles", 32'(halt_cnt), 32'd4);
        chk("to_sel_cycles", 32'(sel_cnt), 32'd0);
        chk("to_err", 32'(last_err), 32'd1);
        bus.halt_ack = 1'b1;

        issue(1'b1, 1'b0, 5'd9, 32'hA5A55A5A, 1'b0);
        bus.resp_ready = 1'b0;
        expect_cmd(1'b0, 1'b0, 5'd9, 32'd0, 1'b0);
        send(1'b0, 1'b0, 5'd9, 32'd0);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); got = bus.resp_valid; end
        if (!got) bound_fail("bp_resp_valid");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("bp_rdata", bus.resp_rdata, 32'hA5A55A5A);
        end
        @(posedge clk); #1; bus.resp_ready = 1'b1;
        wait_done(1'b0);

`ifdef RVR32_REG_DBG_DUMP_EN
        for (int n = 1; n < 32; n++) issue(1'b1, 1'b0, 5'(n), 32'(n * 17), 1'b0);
        clr();
        expect_cmd(1'b0, 1'b1, 5'd0, 32'd0, 1'b0);
        send(1'b0, 1'b1, 5'd0, 32'd0);
        wait_done(1'b1);
        chk("dump_beats", 32'(beat_cnt), 32'd31);
        chk("dump_last_count", 32'(last_cnt), 32'd1);
        chk("dump_x31", last_rdata, 32'h0000020F);

        clr();
        expect_cmd(1'b0, 1'b1, 5'd0, 32'd0, 1'b0);
        send(1'b0, 1'b1, 5'd0, 32'd0);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin @(negedge clk); got = (beat_cnt >= 5); end
        if (!got) bound_fail("dump_progress");
        chk("dump_mid_halt", 32'(bus.halt_req), 32'd1);
        mid_reset("rst_mid_dump");
`else
        clr();
        issue(1'b0, 1'b1, 5'd0, 32'd0, 1'b0);
        chk("nodump_halt_cycles", 32'(halt_cnt), 32'd0);
        chk("nodump_err_last", {30'd0, last_err, last_last}, 32'd3);
        chk("nodump_rdata", last_rdata, 32'd0);
`endif

        bus.halt_ack = 1'b0;
        send(1'b0, 1'b0, 5'd3, 32'd0);
        @(negedge clk);
        chk("mid_cmd_halt", 32'(bus.halt_req), 32'd1);
        mid_reset("rst_mid_cmd");
        bus.halt_ack = 1'b1;

        issue(1'b0, 1'b0, 5'd9, 32'd0, 1'b0);
        chk("post_reset_rd9", last_rdata, mdl[9]);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
